data_mem_resp: RTL

Data-side memory responder for the MiniMIPS32 core. It services the core's data port (`dce`, `we`, `daddr`, `din`) and returns read data on `dm` one cycle later, which is when the WB stage samples it. It holds a byte-writable word RAM and a small memory-mapped peripheral window (LED register, timer, compare, status). It sits outside the core at SoC top level, alongside the instruction ROM.

---
 rtl/data_mem_resp.sv | 125 ++++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// Data-side memory responder: byte-writable word RAM plus a small MMIO window
// (LED, free-running timer, compare, status) with one-cycle registered read data.
module data_mem_resp #(
  parameter int unsigned RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        dce,
  input  logic [3:0]  we,
  input  logic [31:0] daddr,
  input  logic [31:0] din,
  output logic [31:0] dm,
  output logic [31:0] led,
  output logic        timer_irq
);

  localparam int unsigned DW    = 32;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 2 ** RAM_AW;

  localparam logic [1:0] REG_LED    = 2'd0;
  localparam logic [1:0] REG_TIMER  = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [DW-1:0] mem_q [DEPTH];

  logic [DW-1:0] dm_q, dm_d;
  logic [DW-1:0] led_q, led_d;
  logic [DW-1:0] timer_q, timer_d;
  logic [DW-1:0] cmp_q, cmp_d;
  logic          flag_q, flag_d;

  logic              mmio_hit_c;
  logic              wr_any_c;
  logic              ram_wr_c;
  logic              mmio_wr_c;
  logic [1:0]        reg_sel_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic [DW-1:0]     ram_rdata_c;
  logic [DW-1:0]     mmio_rdata_c;
  logic              unused_addr_c;

  // Address decode and access classification
  assign mmio_hit_c    = (daddr[31:4] == MMIO_BASE[31:4]);
  assign wr_any_c      = |we;
  assign ram_wr_c      = dce & ~mmio_hit_c & wr_any_c;
  assign mmio_wr_c     = dce & mmio_hit_c & wr_any_c;
  assign reg_sel_c     = daddr[3:2];
  assign ram_idx_c     = daddr[RAM_AW+1:2];
  assign ram_rdata_c   = mem_q[ram_idx_c];
  assign unused_addr_c = ^daddr[1:0];

  always_comb begin
    mmio_rdata_c = '0;
    case (reg_sel_c)
      REG_LED:    mmio_rdata_c = led_q;
      REG_TIMER:  mmio_rdata_c = timer_q;
      REG_CMP:    mmio_rdata_c = cmp_q;
      REG_STATUS: mmio_rdata_c = {{(DW-1){1'b0}}, flag_q};
      default:    mmio_rdata_c = '0;
    endcase
  end

  // Next-state: every accepted access samples old contents (read-first)
  always_comb begin
    dm_d    = dm_q;
    led_d   = led_q;
    timer_d = timer_q + DW'(1);
    cmp_d   = cmp_q;
    flag_d  = flag_q;

    if (dce) begin
      dm_d = mmio_hit_c ? mmio_rdata_c : ram_rdata_c;
    end

    if (mmio_wr_c) begin
      case (reg_sel_c)
        REG_LED:    led_d   = din;
        REG_TIMER:  timer_d = din;
        REG_CMP:    cmp_d   = din;
        REG_STATUS: if (din[0]) flag_d = 1'b0;
        default:    ;
      endcase
    end

    // A match in the same cycle as a clear keeps the flag set
    if (timer_q == cmp_q) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      dm_q    <= '0;
      led_q   <= '0;
      timer_q <= '0;
      cmp_q   <= '1;
      flag_q  <= 1'b0;
    end else begin
      dm_q    <= dm_d;
      led_q   <= led_d;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
    end
  end

  // RAM array has no reset; per-byte lane update
  always_ff @(posedge cpu_clk_50M) begin
    if (ram_wr_c) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (we[i]) begin
          mem_q[ram_idx_c][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  assign dm        = dm_q;
  assign led       = led_q;
  assign timer_irq = flag_q;

endmodule
